// File: rtl/decoder.sv
// Registered binary-to-one-hot decoder.
//
// Parameters
//   IN_W  : select width (1..6)
//   OUT_W : one-hot width, always 2**IN_W (derived, cannot be overridden)
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset, clears out and out_valid
//   en        : decode enable, sampled on the rising edge
//   a         : binary select, a[IN_W-1] is the MSB
//   out       : registered one-hot result, all zeros when the sampled en was 0
//   out_valid : registered copy of the sampled en
//
// Deassertion of rst_n is expected to be synchronised to clk outside this block.
module decoder #(
  parameter int unsigned IN_W = 2,
  localparam int unsigned OUT_W = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] out,
  output logic             out_valid
);

  logic [OUT_W-1:0] out_d, out_q;
  logic             valid_d, valid_q;

  // Zero default first so a disabled decode never looks at a (X/Z on a is ignored).
  always_comb begin
    out_d   = '0;
    valid_d = en;
    if (en) begin
      out_d[a] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: a default (IN_W=2) instance and an IN_W=3 instance.
// Expected {out_valid,out} values are pushed to a queue when stimulus is driven and
// popped after the following rising edge.
module tb_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] a;
  logic [3:0] out;
  logic       out_valid;

  logic       en2;
  logic [2:0] a2;
  logic [7:0] out2;
  logic       out_valid2;

  int n_cmp;
  int n_bad;

  logic [4:0] q1[$];
  logic [8:0] q2[$];

  decoder u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .a        (a),
    .out      (out),
    .out_valid(out_valid)
  );

  decoder #(.IN_W(3)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en2),
    .a        (a2),
    .out      (out2),
    .out_valid(out_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariants on both instances every cycle: zero or one-hot, nonzero iff valid.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp = n_cmp + 1;
      if (!$onehot0(out) || ((out != 4'b0) != out_valid)) begin
        n_bad = n_bad + 1;
        $display("FAIL invariant_w2: out=%b out_valid=%b, need zero/one-hot and nonzero==valid",
                 out, out_valid);
      end
      n_cmp = n_cmp + 1;
      if (!$onehot0(out2) || ((out2 != 8'b0) != out_valid2)) begin
        n_bad = n_bad + 1;
        $display("FAIL invariant_w3: out=%b out_valid=%b, need zero/one-hot and nonzero==valid",
                 out2, out_valid2);
      end
    end
  end

  // Drive the IN_W=2 instance at the falling edge and push the expected result.
  task automatic drive(input logic e, input logic [1:0] sel);
    logic [3:0] exp_out;
    @(negedge clk);
    en = e;
    a  = sel;
    exp_out = 4'b0;
    if (e === 1'b1) begin
      for (int i = 0; i < 4; i++) exp_out[i] = (sel == i[1:0]);
    end
    q1.push_back({e === 1'b1, exp_out});
  endtask

  task automatic drive2(input logic e, input logic [2:0] sel);
    logic [7:0] exp_out;
    @(negedge clk);
    en2 = e;
    a2  = sel;
    exp_out = 8'b0;
    if (e === 1'b1) begin
      for (int i = 0; i < 8; i++) exp_out[i] = (sel == i[2:0]);
    end
    q2.push_back({e === 1'b1, exp_out});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    a     = 2'd3;
    en2   = 1'b1;
    a2    = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp = n_cmp + 1;
      if (out !== 4'b0000 || out_valid !== 1'b0) begin
        n_bad = n_bad + 1;
        $display("FAIL reset_cycle%0d: out=%b valid=%b, need 0000/0", i, out, out_valid);
      end
      n_cmp = n_cmp + 1;
      if (out2 !== 8'b0 || out_valid2 !== 1'b0) begin
        n_bad = n_bad + 1;
        $display("FAIL reset_w3_cycle%0d: out=%b valid=%b, need 0/0", i, out2, out_valid2);
      end
    end
    @(negedge clk);
    en2   = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [4:0] exp;
    for (int v = 0; v < 8; v++) begin
      drive(v[2], v[1:0]);
      @(posedge clk);
      #1;
      exp = q1.pop_front();
      n_cmp = n_cmp + 1;
      if ({out_valid, out} !== exp) begin
        n_bad = n_bad + 1;
        $display("FAIL sweep_ena%0d: got valid/out=%b/%b, need %b/%b",
                 v, out_valid, out, exp[4], exp[3:0]);
      end
    end
  endtask

  task automatic test_disable();
    logic [4:0] exp;
    logic [4:0] fixed [2];
    fixed[0] = 5'b1_0010;
    fixed[1] = 5'b0_0000;
    drive(1'b1, 2'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        drive(1'b0, 2'd1);
        @(posedge clk);
        #1;
      end
      exp = q1.pop_front();
      n_cmp = n_cmp + 1;
      if ({out_valid, out} !== exp || exp !== fixed[i]) begin
        n_bad = n_bad + 1;
        $display("FAIL disable_step%0d: got valid/out=%b/%b, need %b/%b",
                 i, out_valid, out, fixed[i][4], fixed[i][3:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    logic [1:0] sel;
    for (int i = 0; i < 12; i++) begin
      sel = 2'($urandom_range(0, 3));
      drive(1'b1, sel);
      @(posedge clk);
      #1;
      exp = q1.pop_front();
      n_cmp = n_cmp + 1;
      if ({out_valid, out} !== exp) begin
        n_bad = n_bad + 1;
        $display("FAIL back_to_back%0d: a=%0d got valid/out=%b/%b, need %b/%b",
                 i, sel, out_valid, out, exp[4], exp[3:0]);
      end
    end
  endtask

  task automatic test_x_on_a();
    logic [4:0] exp;
    drive(1'b0, 2'bxx);
    @(posedge clk);
    #1;
    exp = q1.pop_front();
    n_cmp = n_cmp + 1;
    if ({out_valid, out} !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL x_on_a: got valid/out=%b/%b, need 0/0000", out_valid, out);
    end
    drive(1'b0, 2'bzz);
    @(posedge clk);
    #1;
    exp = q1.pop_front();
    n_cmp = n_cmp + 1;
    if ({out_valid, out} !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL z_on_a: got valid/out=%b/%b, need 0/0000", out_valid, out);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] exp;
    drive(1'b1, 2'd2);
    @(posedge clk);
    #1;
    exp = q1.pop_front();
    n_cmp = n_cmp + 1;
    if (out !== 4'b0100 || exp[3:0] !== 4'b0100) begin
      n_bad = n_bad + 1;
      $display("FAIL async_pre: out=%b, need 0100", out);
    end
    // Pulse reset between edges; outputs must clear without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp = n_cmp + 1;
    if (out !== 4'b0000 || out_valid !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL async_clear: out=%b valid=%b, need 0000/0", out, out_valid);
    end
    #1;
    rst_n = 1'b1;
    q1.push_back(5'b1_0100);
    @(posedge clk);
    #1;
    exp = q1.pop_front();
    n_cmp = n_cmp + 1;
    if ({out_valid, out} !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL async_first_edge: got valid/out=%b/%b, need 1/0100", out_valid, out);
    end
  endtask

  task automatic test_param();
    logic [8:0] exp;
    for (int v = 0; v < 8; v++) begin
      drive2(1'b1, v[2:0]);
      @(posedge clk);
      #1;
      exp = q2.pop_front();
      n_cmp = n_cmp + 1;
      if ({out_valid2, out2} !== exp) begin
        n_bad = n_bad + 1;
        $display("FAIL param_w3_a%0d: got valid/out=%b/%b, need %b/%b",
                 v, out_valid2, out2, exp[8], exp[7:0]);
      end
    end
    n_cmp = n_cmp + 1;
    if (out2 !== 8'b1000_0000) begin
      n_bad = n_bad + 1;
      $display("FAIL param_w3_a7_literal: out=%b, need 10000000", out2);
    end
    drive2(1'b0, 3'd7);
    @(posedge clk);
    #1;
    exp = q2.pop_front();
    n_cmp = n_cmp + 1;
    if ({out_valid2, out2} !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL param_w3_disable: got valid/out=%b/%b, need 0/00000000",
               out_valid2, out2);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_sweep();
    test_disable();
    test_back_to_back();
    test_x_on_a();
    test_async_reset();
    test_param();
    n_cmp = n_cmp + 1;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, need 0/0", q1.size(), q2.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
